// File: rtl/mem_seq_ctrl_pkg.sv
// Shared types for the Mini-SRC memory-path sequencer: state and op encodings
// plus the Moore output decode used by mem_seq_ctrl.
package mem_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    F_ADDR,
    F_WAIT,
    F_IR,
    L_ADDR,
    L_WAIT,
    L_DONE,
    S_ADDR,
    S_DATA,
    S_WAIT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_FETCH,
    OP_LOAD,
    OP_STORE
  } op_t;

  typedef struct packed {
    logic pcOut;
    logic incPc;
    logic marIn;
    logic mdrIn;
    logic read;
    logic mdrOut;
    logic irIn;
    logic memReq;
    logic memWe;
    logic busy;
    logic done;
  } strobes_t;

  // Fetch beats load beats store; losers are simply dropped.
  function automatic op_t pickOp(input logic fetchReq, input logic ldReq, input logic stReq);
    op_t op;
    op = OP_NONE;
    if (fetchReq) op = OP_FETCH;
    else if (ldReq) op = OP_LOAD;
    else if (stReq) op = OP_STORE;
    return op;
  endfunction

  function automatic logic isWait(input state_t s);
    return (s == F_WAIT) || (s == L_WAIT) || (s == S_WAIT);
  endfunction

  function automatic strobes_t decodeState(input state_t s);
    strobes_t o;
    o = '0;
    o.busy = (s != IDLE);
    case (s)
      F_ADDR: begin
        o.pcOut = 1'b1;
        o.marIn = 1'b1;
        o.incPc = 1'b1;
      end
      F_WAIT, L_WAIT: begin
        o.memReq = 1'b1;
        o.read   = 1'b1;
        o.mdrIn  = 1'b1;
      end
      F_IR: begin
        o.mdrOut = 1'b1;
        o.irIn   = 1'b1;
        o.done   = 1'b1;
      end
      L_ADDR, S_ADDR: o.marIn = 1'b1;
      L_DONE: begin
        o.mdrOut = 1'b1;
        o.done   = 1'b1;
      end
      S_DATA: o.mdrIn = 1'b1;
      S_WAIT: begin
        o.memReq = 1'b1;
        o.memWe  = 1'b1;
      end
      S_DONE: o.done = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mem_seq_ctrl_if.sv
// Control-unit / datapath / memory handshake bundle for mem_seq_ctrl.
// master = the sequencer, slave = the surrounding control unit and memory.
interface mem_seq_ctrl_if;

  logic fetch_req;
  logic ld_req;
  logic st_req;
  logic mem_ack;
  logic PCout;
  logic IncPC;
  logic MARin;
  logic MDRin;
  logic Read;
  logic MDRout;
  logic IRin;
  logic mem_req;
  logic mem_we;
  logic busy;
  logic done;
  logic err;

  modport master (
    input  fetch_req, ld_req, st_req, mem_ack,
    output PCout, IncPC, MARin, MDRin, Read, MDRout, IRin,
    output mem_req, mem_we, busy, done, err
  );

  modport slave (
    output fetch_req, ld_req, st_req, mem_ack,
    input  PCout, IncPC, MARin, MDRin, Read, MDRout, IRin,
    input  mem_req, mem_we, busy, done, err
  );

endinterface

// File: rtl/mem_seq_ctrl_wait_timer.sv
// Saturating wait-state counter; only instantiated when MEM_TIMEOUT_EN is defined.
// expired fires on the low-ack cycle that would bring the count to TIMEOUT_CYCLES.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic clock,
  input  logic clear,
  input  logic start,
  input  logic tick,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_COUNT  = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (clear || start) begin
      r_count <= '0;
    end else if (tick && (r_count != MAX_COUNT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = tick && (r_count == LAST_COUNT);

endmodule

// File: rtl/mem_seq_ctrl.sv
// Memory-path sequencer (PC/MAR/MDR/IR + memory handshake) for Mini-SRC.
// Define MEM_TIMEOUT_EN to abort WAIT states after TIMEOUT_CYCLES low-ack cycles.
module mem_seq_ctrl
  import mem_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic           clock,
  input  logic           clear,
  mem_seq_ctrl_if.master bus
);

  state_t   r_state;
  state_t   w_stateNext;
  strobes_t w_strobes;
  op_t      w_op;
  logic     w_expired;

  if (CNT_W < $clog2(TIMEOUT_CYCLES + 1)) begin : gBadCfg
    $error("mem_seq_ctrl: CNT_W too narrow for TIMEOUT_CYCLES");
  end

`ifdef MEM_TIMEOUT_EN
  logic w_timerStart;
  logic w_timerTick;
  logic r_err;

  // The state just before each WAIT restarts the count for the coming wait.
  assign w_timerStart = (r_state == F_ADDR) || (r_state == L_ADDR) || (r_state == S_DATA);
  assign w_timerTick  = isWait(r_state) && !bus.mem_ack;

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timer (
    .clock  (clock),
    .clear  (clear),
    .start  (w_timerStart),
    .tick   (w_timerTick),
    .expired(w_expired)
  );

  always_ff @(posedge clock) begin
    if (clear) r_err <= 1'b0;
    else       r_err <= w_expired;
  end

  assign bus.err = r_err;
`else
  assign w_expired = 1'b0;
  assign bus.err   = 1'b0;
`endif

  assign w_op = pickOp(bus.fetch_req, bus.ld_req, bus.st_req);

  always_ff @(posedge clock) begin
    if (clear) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: begin
        case (w_op)
          OP_FETCH: w_stateNext = F_ADDR;
          OP_LOAD:  w_stateNext = L_ADDR;
          OP_STORE: w_stateNext = S_ADDR;
          default:  w_stateNext = IDLE;
        endcase
      end
      F_ADDR: w_stateNext = F_WAIT;
      F_WAIT: begin
        if (bus.mem_ack)    w_stateNext = F_IR;
        else if (w_expired) w_stateNext = IDLE;
      end
      F_IR:   w_stateNext = IDLE;
      L_ADDR: w_stateNext = L_WAIT;
      L_WAIT: begin
        if (bus.mem_ack)    w_stateNext = L_DONE;
        else if (w_expired) w_stateNext = IDLE;
      end
      L_DONE: w_stateNext = IDLE;
      S_ADDR: w_stateNext = S_DATA;
      S_DATA: w_stateNext = S_WAIT;
      S_WAIT: begin
        if (bus.mem_ack)    w_stateNext = S_DONE;
        else if (w_expired) w_stateNext = IDLE;
      end
      S_DONE:  w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Pure Moore decode: no request or ack path reaches these outputs.
  assign w_strobes = decodeState(r_state);

  assign bus.PCout   = w_strobes.pcOut;
  assign bus.IncPC   = w_strobes.incPc;
  assign bus.MARin   = w_strobes.marIn;
  assign bus.MDRin   = w_strobes.mdrIn;
  assign bus.Read    = w_strobes.read;
  assign bus.MDRout  = w_strobes.mdrOut;
  assign bus.IRin    = w_strobes.irIn;
  assign bus.mem_req = w_strobes.memReq;
  assign bus.mem_we  = w_strobes.memWe;
  assign bus.busy    = w_strobes.busy;
  assign bus.done    = w_strobes.done;

endmodule
